// File: rtl/count_tick_gen_pkg.sv
// Shared types and default widths for the count_tick_gen tick source.
package count_tick_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    BURST = 2'b10
  } state_t;

  localparam int DIV_W_DEF   = 8;
  localparam int BURST_W_DEF = 4;

endpackage

// File: rtl/count_tick_gen_prescale_core.sv
// Prescale core for count_tick_gen: a modulo counter that wraps when it reaches
// the divide ratio latched at load_div. clear holds/returns the count to zero.
module count_tick_gen_prescale_core #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load_div,
  input  logic [DIV_W-1:0] div,
  output logic             wrap
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_q;

  // Latch the ratio on entry; otherwise count 0..div_q and fold back to zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      div_q <= '0;
    end else if (load_div) begin
      div_q <= div;
      cnt   <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (cnt == div_q) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

  assign wrap = (cnt == div_q);

endmodule

// File: rtl/count_tick_gen.sv
// count_tick_gen: divides clk into 1-cycle tick pulses for the up-counter
// enable. Free-run while 'run' is high; optional fixed-length bursts.
// Build option: COUNT_TICK_GEN_BURST_EN enables the BURST state, the
// remaining-tick counter and burst_done. Without it, burst_start/burst_len
// are ignored and burst_done is tied low.
module count_tick_gen
  import count_tick_gen_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int BURST_W = BURST_W_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               run,
  input  logic [DIV_W-1:0]   div,
  input  logic               burst_start,
  input  logic [BURST_W-1:0] burst_len,
  output logic               tick,
  output logic               busy,
  output logic               burst_done
);

  state_t state;
  state_t state_next;
  logic   tick_next;
  logic   load_div;
  logic   clear;
  logic   wrap;

`ifdef COUNT_TICK_GEN_BURST_EN
  logic [BURST_W-1:0] rem;
  logic               done_next;
`else
  logic unused_burst_in;
  assign unused_burst_in = burst_start ^ (^burst_len);
`endif

  // Counter returns to zero whenever the FSM is (or is going) idle.
  assign clear = (state_next == IDLE);

  count_tick_gen_prescale_core #(
    .DIV_W(DIV_W)
  ) u_prescale_core (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (clear),
    .load_div (load_div),
    .div      (div),
    .wrap     (wrap)
  );

  // Next-state and next-output decode; burst requests win over run in IDLE.
  always_comb begin
    state_next = state;
    load_div   = 1'b0;
    tick_next  = 1'b0;
`ifdef COUNT_TICK_GEN_BURST_EN
    done_next  = 1'b0;
`endif
    case (state)
      IDLE: begin
`ifdef COUNT_TICK_GEN_BURST_EN
        if (burst_start && (burst_len != '0)) begin
          state_next = BURST;
          load_div   = 1'b1;
        end else
`endif
        if (run) begin
          state_next = RUN;
          load_div   = 1'b1;
        end
      end
      RUN: begin
        if (!run) begin
          state_next = IDLE;
        end else begin
          tick_next = wrap;
        end
      end
`ifdef COUNT_TICK_GEN_BURST_EN
      BURST: begin
        if (wrap) begin
          tick_next = 1'b1;
          if (rem == BURST_W'(1)) begin
            done_next  = 1'b1;
            state_next = IDLE;
          end
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // State register and registered tick output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      tick  <= 1'b0;
    end else begin
      state <= state_next;
      tick  <= tick_next;
    end
  end

`ifdef COUNT_TICK_GEN_BURST_EN
  // Remaining-tick counter: loaded on burst entry, decremented per tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem        <= '0;
      burst_done <= 1'b0;
    end else begin
      burst_done <= done_next;
      if ((state == IDLE) && (state_next == BURST)) begin
        rem <= burst_len;
      end else if ((state == BURST) && wrap) begin
        rem <= rem - BURST_W'(1);
      end
    end
  end
`else
  assign burst_done = 1'b0;
`endif

  assign busy = (state != IDLE);

endmodule
